burst_mem_arbiter: RTL and testbench
====================================

Name: burst_mem_arbiter

Overview:
- Second-generation DDR4 arbiter sitting between the NUM_CORES solver cores (BCP/CAE readers, learning writers) and the single simplified AXI4 master port.
- Unlike the first-generation combinational mux, it owns the read burst for its full duration. One read is outstanding, and read data is routed to the owning core until the last beat.
- Address/data width and burst-length width are parametrised.
- Read priority is kept, but a write-starvation counter forces a write through after a bounded wait.

Parameters:
- NUM_CORES, 4, number of requesting cores (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 8, burst length field width; len = beats-1
- WR_STARVE_LIMIT, 16, cycles a pending write may be bypassed by reads before it is forced (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- core_read_req[NUM_CORES]  in  1 each  read request; held until grant
- core_read_addr[NUM_CORES]  in  ADDR_W each  burst start address
- core_read_len[NUM_CORES]  in  LEN_W each  beats-1
- core_read_grant[NUM_CORES]  out  1 each  1-cycle pulse, address accepted by DDR
- core_read_data[NUM_CORES]  out  DATA_W each  routed beat; 0 for non-owners
- core_read_valid[NUM_CORES]  out  1 each  beat valid, owner only
- core_read_last[NUM_CORES]  out  1 each  final beat of burst, owner only
- core_write_req[NUM_CORES]  in  1 each  single-beat write request; held until grant
- core_write_addr[NUM_CORES]  in  ADDR_W each  write address
- core_write_data[NUM_CORES]  in  DATA_W each  write data
- core_write_grant[NUM_CORES]  out  1 each  1-cycle pulse, write accepted
- ddr_read_req  out  1  read address valid
- ddr_read_addr  out  ADDR_W  latched address
- ddr_read_len  out  LEN_W  latched length
- ddr_read_grant  in  1  read address accepted
- ddr_read_data  in  DATA_W  read beat
- ddr_read_valid  in  1  read beat valid
- ddr_write_req  out  1  write valid
- ddr_write_addr  out  ADDR_W  latched address
- ddr_write_data  out  DATA_W  latched data
- ddr_write_grant  in  1  write accepted
- rd_busy  out  1  read FSM not idle
- err_spurious  out  1  sticky: ddr_read_valid arrived outside R_DATA

Behaviour:
Reset:
- All outputs 0.
- Read and write round-robin pointers 0.
- FSMs idle; starve counter 0; err_spurious 0.
- Reset asserted mid-burst aborts immediately with no further routing.

Read FSM (R_IDLE, R_ADDR, R_DATA):
- R_IDLE: if any core_read_req, select the first requester scanning from rd_ptr upward (mod NUM_CORES). On the next edge, latch owner/addr/len, set beat_cnt=0, go to R_ADDR.
- R_ADDR: ddr_read_req=1 with latched addr/len held stable. While ddr_read_grant=1: core_read_grant[owner] pulses combinationally that cycle; rd_ptr<=owner+1 mod NUM_CORES; go to R_DATA.
- R_DATA: each ddr_read_valid beat drives core_read_data/valid[owner] combinationally and increments beat_cnt. core_read_last[owner]=1 when beat_cnt==len. On the last beat go to R_IDLE.
- len=0 means a single beat, with last on the first beat.
- beat_cnt is LEN_W bits; len = all-ones gives 2^LEN_W beats with no overflow.
- ddr_read_valid in R_IDLE/R_ADDR: beat dropped, err_spurious<=1.
- A new selection happens only in R_IDLE, so back-to-back bursts have 1 idle cycle between them.

Write FSM (W_IDLE, W_REQ):
- W_IDLE: wr_allow = (no core_read_req asserted AND read FSM != R_ADDR) OR starve_cnt==WR_STARVE_LIMIT.
- If wr_allow and any core_write_req: select round-robin from wr_ptr, latch owner/addr/data, go to W_REQ.
- W_REQ: ddr_write_req=1. While ddr_write_grant=1: core_write_grant[owner] pulses; wr_ptr<=owner+1 mod N; starve_cnt<=0; go to W_IDLE.
- starve_cnt: increments in W_IDLE while any core_write_req is asserted and wr_allow=0; saturates at WR_STARVE_LIMIT.
- Write issue may overlap read R_DATA (independent channels).
- Simultaneous read and write selection in one cycle is legal only when starve forces the write.

General:
- Core requests dropped before grant are not required to be handled; the latched request still completes, and the grant pulse is ignored.
- NUM_CORES=1: pointer width 1; pointer is always 0.

Decomposition:
- Package mem_arb_pkg holds:
  - rd_state_e, wr_state_e
  - function rr_pick(req vector, ptr) returning index + found
  - localparam PTR_W = NUM_CORES>1 ? $clog2(NUM_CORES) : 1
- Sub-module rr_select: combinational round-robin picker, instanced twice (read and write).

Test Plan:
- Cores 0,2 read simultaneously, len=3, grant after 2 cycles. Required:
  - core0 granted first and receives 4 beats with last on beat 4;
  - core2 granted next (rd_ptr=1 skips to 2);
  - core2 outputs stay 0 during core0's burst.
- len=0 single read. Required: valid and last both high on the first beat; FSM returns to R_IDLE next cycle.
- Core1 write pending while cores 0/3 issue continuous reads, WR_STARVE_LIMIT=4. Required: write issued after starve_cnt reaches 4; core_write_grant[1] pulses; counter returns to 0.
- ddr_read_valid pulsed in R_IDLE. Required: err_spurious=1 and stays 1; no core_read_valid asserted.
- rst_n low mid-burst after beat 2 of 8. Required: all outputs 0 immediately; after reset a fresh request is granted starting from core 0.
- All 4 cores writing with no reads and immediate grants. Required: grants in order 0,1,2,3,0; ddr_write_data matches each owner's data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and round-robin search used by both arbiter channels.
// Combinational helpers only; nothing here holds state.
package mem_arb_pkg;

    localparam int MAX_CORES = 32;
    localparam int MAX_PTR_W = 5;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_REQ  = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_PTR_W-1:0] idx;
    } pick_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester at or after ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_CORES-1:0] req,
                                      input int unsigned          n,
                                      input int unsigned          ptr);
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int unsigned i = 0; i < MAX_CORES; i++) begin
            j = (ptr + i) % n;
            if (i < n && !p.found && req[j]) begin
                p.found = 1'b1;
                p.idx   = MAX_PTR_W'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: zero latency, no state.
// Scans upward from i_ptr; o_found low when no request is present.
module rr_select
    import mem_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_found,
    output logic [PTR_W-1:0] o_idx
);

    pick_t w_pick;

    always_comb begin
        w_pick  = rr_pick(MAX_CORES'(i_req), N, 32'(i_ptr));
        o_found = w_pick.found;
        o_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (w_pick.idx == MAX_PTR_W'(k)) o_idx = PTR_W'(k);
        end
    end

endmodule

// File: rtl/burst_mem_arbiter.sv
// Burst-owning DDR arbiter: one read outstanding, data routed to its owner until last beat.
// Reads have priority; a write bypassed for WR_STARVE_LIMIT cycles is forced through.
module burst_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int LEN_W           = 8,
    parameter int WR_STARVE_LIMIT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        i_core_read_req,
    input  logic [NUM_CORES*ADDR_W-1:0] i_core_read_addr,
    input  logic [NUM_CORES*LEN_W-1:0]  i_core_read_len,
    output logic [NUM_CORES-1:0]        o_core_read_grant,
    output logic [NUM_CORES*DATA_W-1:0] o_core_read_data,
    output logic [NUM_CORES-1:0]        o_core_read_valid,
    output logic [NUM_CORES-1:0]        o_core_read_last,
    input  logic [NUM_CORES-1:0]        i_core_write_req,
    input  logic [NUM_CORES*ADDR_W-1:0] i_core_write_addr,
    input  logic [NUM_CORES*DATA_W-1:0] i_core_write_data,
    output logic [NUM_CORES-1:0]        o_core_write_grant,
    output logic                        o_ddr_read_req,
    output logic [ADDR_W-1:0]           o_ddr_read_addr,
    output logic [LEN_W-1:0]            o_ddr_read_len,
    input  logic                        i_ddr_read_grant,
    input  logic [DATA_W-1:0]           i_ddr_read_data,
    input  logic                        i_ddr_read_valid,
    output logic                        o_ddr_write_req,
    output logic [ADDR_W-1:0]           o_ddr_write_addr,
    output logic [DATA_W-1:0]           o_ddr_write_data,
    input  logic                        i_ddr_write_grant,
    output logic                        o_rd_busy,
    output logic                        o_err_spurious
);

    localparam int PTR_W = ptr_width(NUM_CORES);
    localparam int ST_W  = $clog2(WR_STARVE_LIMIT + 1);

    rd_state_e          r_rd_state;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_rd_owner;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [LEN_W-1:0]   r_rd_len;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic               r_err_spurious;

    wr_state_e          r_wr_state;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_wr_owner;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [ST_W-1:0]    r_starve_cnt;

    logic               w_rd_found;
    logic [PTR_W-1:0]   w_rd_idx;
    logic               w_wr_found;
    logic [PTR_W-1:0]   w_wr_idx;
    logic               w_rd_last;
    logic               w_starved;
    logic               w_wr_allow;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_CORES - 1) ? '0 : p + 1'b1;
    endfunction

    rr_select #(.N(NUM_CORES), .PTR_W(PTR_W)) u_rd_sel (
        .i_req   (i_core_read_req),
        .i_ptr   (r_rd_ptr),
        .o_found (w_rd_found),
        .o_idx   (w_rd_idx)
    );

    rr_select #(.N(NUM_CORES), .PTR_W(PTR_W)) u_wr_sel (
        .i_req   (i_core_write_req),
        .i_ptr   (r_wr_ptr),
        .o_found (w_wr_found),
        .o_idx   (w_wr_idx)
    );

    // Counter is LEN_W wide and compared, never wrapped, so len all-ones is safe.
    assign w_rd_last  = (r_beat_cnt == r_rd_len);
    assign w_starved  = (r_starve_cnt == ST_W'(WR_STARVE_LIMIT));
    assign w_wr_allow = (!(|i_core_read_req) && r_rd_state != R_ADDR) || w_starved;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state     <= R_IDLE;
            r_rd_ptr       <= '0;
            r_rd_owner     <= '0;
            r_rd_addr      <= '0;
            r_rd_len       <= '0;
            r_beat_cnt     <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            if (i_ddr_read_valid && r_rd_state != R_DATA) r_err_spurious <= 1'b1;
            case (r_rd_state)
                R_IDLE: begin
                    if (w_rd_found) begin
                        r_rd_owner <= w_rd_idx;
                        r_rd_addr  <= i_core_read_addr[w_rd_idx*ADDR_W +: ADDR_W];
                        r_rd_len   <= i_core_read_len[w_rd_idx*LEN_W +: LEN_W];
                        r_beat_cnt <= '0;
                        r_rd_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (i_ddr_read_grant) begin
                        r_rd_ptr   <= next_ptr(r_rd_owner);
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_ddr_read_valid) begin
                        if (w_rd_last) r_rd_state <= R_IDLE;
                        else           r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state   <= W_IDLE;
            r_wr_ptr     <= '0;
            r_wr_owner   <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_allow && w_wr_found) begin
                        r_wr_owner <= w_wr_idx;
                        r_wr_addr  <= i_core_write_addr[w_wr_idx*ADDR_W +: ADDR_W];
                        r_wr_data  <= i_core_write_data[w_wr_idx*DATA_W +: DATA_W];
                        r_wr_state <= W_REQ;
                    end else if (|i_core_write_req && !w_wr_allow && !w_starved) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                W_REQ: begin
                    if (i_ddr_write_grant) begin
                        r_wr_ptr     <= next_ptr(r_wr_owner);
                        r_starve_cnt <= '0;
                        r_wr_state   <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        o_core_read_grant  = '0;
        o_core_read_data   = '0;
        o_core_read_valid  = '0;
        o_core_read_last   = '0;
        o_core_write_grant = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            o_core_read_grant[k]  = (r_rd_state == R_ADDR) && i_ddr_read_grant &&
                                    (r_rd_owner == PTR_W'(k));
            o_core_read_valid[k]  = (r_rd_state == R_DATA) && i_ddr_read_valid &&
                                    (r_rd_owner == PTR_W'(k));
            o_core_read_last[k]   = o_core_read_valid[k] && w_rd_last;
            if (o_core_read_valid[k]) o_core_read_data[k*DATA_W +: DATA_W] = i_ddr_read_data;
            o_core_write_grant[k] = (r_wr_state == W_REQ) && i_ddr_write_grant &&
                                    (r_wr_owner == PTR_W'(k));
        end
    end

    assign o_ddr_read_req   = (r_rd_state == R_ADDR);
    assign o_ddr_read_addr  = r_rd_addr;
    assign o_ddr_read_len   = r_rd_len;
    assign o_ddr_write_req  = (r_wr_state == W_REQ);
    assign o_ddr_write_addr = r_wr_addr;
    assign o_ddr_write_data = r_wr_data;
    assign o_rd_busy        = (r_rd_state != R_IDLE);
    assign o_err_spurious   = r_err_spurious;

endmodule

// File: tb/tb_burst_mem_arbiter.sv
// Directed bench for burst_mem_arbiter: 4 cores, 32-bit paths, write starve limit 4.
module tb_burst_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   core_read_req;
    logic [127:0] core_read_addr;
    logic [31:0]  core_read_len;
    logic [3:0]   core_read_grant;
    logic [127:0] core_read_data;
    logic [3:0]   core_read_valid;
    logic [3:0]   core_read_last;
    logic [3:0]   core_write_req;
    logic [127:0] core_write_addr;
    logic [127:0] core_write_data;
    logic [3:0]   core_write_grant;
    logic         ddr_read_req;
    logic [31:0]  ddr_read_addr;
    logic [7:0]   ddr_read_len;
    logic         ddr_read_grant;
    logic [31:0]  ddr_read_data;
    logic         ddr_read_valid;
    logic         ddr_write_req;
    logic [31:0]  ddr_write_addr;
    logic [31:0]  ddr_write_data;
    logic         ddr_write_grant;
    logic         rd_busy;
    logic         err_spurious;

    int n_cmp = 0;
    int n_bad = 0;

    burst_mem_arbiter #(
        .NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .LEN_W(8), .WR_STARVE_LIMIT(4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_core_read_req    (core_read_req),
        .i_core_read_addr   (core_read_addr),
        .i_core_read_len    (core_read_len),
        .o_core_read_grant  (core_read_grant),
        .o_core_read_data   (core_read_data),
        .o_core_read_valid  (core_read_valid),
        .o_core_read_last   (core_read_last),
        .i_core_write_req   (core_write_req),
        .i_core_write_addr  (core_write_addr),
        .i_core_write_data  (core_write_data),
        .o_core_write_grant (core_write_grant),
        .o_ddr_read_req     (ddr_read_req),
        .o_ddr_read_addr    (ddr_read_addr),
        .o_ddr_read_len     (ddr_read_len),
        .i_ddr_read_grant   (ddr_read_grant),
        .i_ddr_read_data    (ddr_read_data),
        .i_ddr_read_valid   (ddr_read_valid),
        .o_ddr_write_req    (ddr_write_req),
        .o_ddr_write_addr   (ddr_write_addr),
        .o_ddr_write_data   (ddr_write_data),
        .i_ddr_write_grant  (ddr_write_grant),
        .o_rd_busy          (rd_busy),
        .o_err_spurious     (err_spurious)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1-2 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        core_read_req   = '0;
        core_read_addr  = '0;
        core_read_len   = '0;
        core_write_req  = '0;
        core_write_addr = '0;
        core_write_data = '0;
        ddr_read_grant  = 1'b0;
        ddr_read_data   = '0;
        ddr_read_valid  = 1'b0;
        ddr_write_grant = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("rst_rd_busy",  rd_busy, 0);
        check("rst_ddr_rreq", ddr_read_req, 0);
        check("rst_ddr_wreq", ddr_write_req, 0);
        check("rst_err",      err_spurious, 0);
        check("rst_rgrant",   core_read_grant, 0);
        check("rst_wgrant",   core_write_grant, 0);

        // Cores 0 and 2 read len=3 together; DDR accepts after 2 wait cycles.
        core_read_addr[31:0]  = 32'h0000_1000;
        core_read_addr[95:64] = 32'h0000_2000;
        core_read_len[7:0]    = 8'd3;
        core_read_len[23:16]  = 8'd3;
        core_read_req         = 4'b0101;
        cyc();
        check("t1_ddr_rreq", ddr_read_req, 1);
        check("t1_addr0",    ddr_read_addr, 32'h0000_1000);
        check("t1_len0",     ddr_read_len, 3);
        check("t1_busy",     rd_busy, 1);
        cyc();
        cyc();
        check("t1_wait_grant", core_read_grant, 0);
        ddr_read_grant = 1'b1;
        #1;
        check("t1_grant0", core_read_grant, 4'b0001);
        cyc();
        ddr_read_grant = 1'b0;
        core_read_req  = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            ddr_read_valid = 1'b1;
            ddr_read_data  = 32'h0000_00A0 + b;
            #1;
            check("t1_valid0", core_read_valid, 4'b0001);
            check("t1_data0",  core_read_data[31:0], 32'h0000_00A0 + b);
            check("t1_data2",  core_read_data[95:64], 0);
            check("t1_last0",  core_read_last, (b == 3) ? 4'b0001 : 4'b0000);
            cyc();
        end
        ddr_read_valid = 1'b0;
        #1;
        check("t1_idle_gap", rd_busy, 0);
        cyc();
        check("t1_addr2", ddr_read_addr, 32'h0000_2000);
        ddr_read_grant = 1'b1;
        #1;
        check("t1_grant2", core_read_grant, 4'b0100);
        cyc();
        ddr_read_grant = 1'b0;
        core_read_req  = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            ddr_read_valid = 1'b1;
            ddr_read_data  = 32'h0000_00B0 + b;
            #1;
            check("t1_valid2", core_read_valid, 4'b0100);
            check("t1_last2",  core_read_last, (b == 3) ? 4'b0100 : 4'b0000);
            cyc();
        end
        ddr_read_valid = 1'b0;

        // Single-beat read from core 1 (rd_ptr=3 wraps past 0 to 1).
        core_read_addr[63:32] = 32'h0000_3000;
        core_read_len[15:8]   = 8'd0;
        core_read_req         = 4'b0010;
        cyc();
        check("t2_addr1", ddr_read_addr, 32'h0000_3000);
        ddr_read_grant = 1'b1;
        #1;
        check("t2_grant1", core_read_grant, 4'b0010);
        cyc();
        ddr_read_grant = 1'b0;
        core_read_req  = 4'b0000;
        ddr_read_valid = 1'b1;
        ddr_read_data  = 32'h0000_0055;
        #1;
        check("t2_valid1", core_read_valid, 4'b0010);
        check("t2_last1",  core_read_last, 4'b0010);
        check("t2_data1",  core_read_data[63:32], 32'h0000_0055);
        cyc();
        ddr_read_valid = 1'b0;
        #1;
        check("t2_idle", rd_busy, 0);

        // Stray read beat while idle.
        ddr_read_valid = 1'b1;
        ddr_read_data  = 32'hBAD0_BAD0;
        #1;
        check("t4_no_valid", core_read_valid, 0);
        check("t4_no_data",  core_read_data, 0);
        cyc();
        ddr_read_valid = 1'b0;
        #1;
        check("t4_err_set", err_spurious, 1);
        cyc();
        cyc();
        check("t4_err_sticky", err_spurious, 1);

        // Core 1 write starved by reads from 0/3, forced after 4 bypass cycles.
        core_read_addr[127:96]  = 32'h0000_5000;
        core_read_len[31:24]    = 8'd7;
        core_read_req           = 4'b1001;
        core_write_addr[63:32]  = 32'h0000_4000;
        core_write_data[63:32]  = 32'h0000_DEAD;
        core_write_req          = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("t3_wreq_held", ddr_write_req, 0);
        end
        check("t3_starve_cnt", dut.r_starve_cnt, 4);
        check("t3_rd_owner3", ddr_read_addr, 32'h0000_5000);
        cyc();
        check("t3_wreq_forced", ddr_write_req, 1);
        check("t3_waddr",       ddr_write_addr, 32'h0000_4000);
        check("t3_wdata",       ddr_write_data, 32'h0000_DEAD);
        ddr_write_grant = 1'b1;
        #1;
        check("t3_wgrant1", core_write_grant, 4'b0010);
        cyc();
        ddr_write_grant = 1'b0;
        core_write_req  = 4'b0000;
        #1;
        check("t3_starve_clr", dut.r_starve_cnt, 0);
        check("t3_wreq_done",  ddr_write_req, 0);

        // Core 3 burst of 8, reset lands after beat 2.
        ddr_read_grant = 1'b1;
        #1;
        check("t5_grant3", core_read_grant, 4'b1000);
        cyc();
        ddr_read_grant = 1'b0;
        core_read_req  = 4'b0000;
        for (int b = 0; b < 2; b++) begin
            ddr_read_valid = 1'b1;
            ddr_read_data  = 32'h0000_00C0 + b;
            #1;
            check("t5_valid3", core_read_valid, 4'b1000);
            cyc();
        end
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", core_read_valid, 0);
        check("t5_rst_data",  core_read_data, 0);
        check("t5_rst_busy",  rd_busy, 0);
        check("t5_rst_err",   err_spurious, 0);
        check("t5_rst_rreq",  ddr_read_req, 0);
        check("t5_rst_raddr", ddr_read_addr, 0);
        check("t5_rst_wdata", ddr_write_data, 0);
        ddr_read_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        core_read_addr[63:32] = 32'h0000_7000;
        core_read_req         = 4'b1010;
        cyc();
        check("t5_fresh_addr", ddr_read_addr, 32'h0000_7000);
        check("t5_fresh_req",  ddr_read_req, 1);
        ddr_read_grant = 1'b1;
        #1;
        check("t5_fresh_grant", core_read_grant, 4'b0010);
        cyc();
        ddr_read_grant = 1'b0;
        core_read_req  = 4'b0000;
        ddr_read_valid = 1'b1;
        ddr_read_data  = 32'h0000_0077;
        #1;
        check("t5_fresh_last", core_read_last, 4'b0010);
        cyc();
        ddr_read_valid = 1'b0;

        // All four cores write, DDR accepts immediately.
        for (int k = 0; k < 4; k++) begin
            core_write_addr[k*32 +: 32] = 32'h0000_0100 * (k + 1);
            core_write_data[k*32 +: 32] = 32'h1111_0000 + k;
        end
        core_write_req  = 4'b1111;
        ddr_write_grant = 1'b1;
        for (int g = 0; g < 5; g++) begin
            cyc();
            check("t6_wreq",   ddr_write_req, 1);
            check("t6_wgrant", core_write_grant, 4'b0001 << (g % 4));
            check("t6_wdata",  ddr_write_data, 32'h1111_0000 + (g % 4));
            check("t6_waddr",  ddr_write_addr, 32'h0000_0100 * ((g % 4) + 1));
            cyc();
            check("t6_gap", core_write_grant, 0);
        end
        core_write_req  = 4'b0000;
        ddr_write_grant = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
